gray_counter: RTL

- Parametrised WIDTH-bit up/down counter that presents its count in both binary and Gray code. Both outputs are registered and cycle-aligned.
- Successor to the team's fixed 4-bit combinational binary-to-Gray converter. Adds sequencing, parallel load, direction control, wrap/saturate mode and terminal-count/overflow reporting.
- Used as a Gray-coded pointer source for clock-domain-crossing FIFOs and for position/step sequencing.

---
 rtl/gray_pkg.sv | 48 ++++
 rtl/bin2gray_conv.sv | 14 +
 rtl/gray_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-coded counter family: step classification,
// width-independent binary/Gray conversion helpers and an all-ones constant builder.
package gray_pkg;

    // Widest counter the helpers support; narrower values are zero-extended.
    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // What the counter does on a given clock edge.
    typedef enum logic [1:0] {
        STEP_HOLD  = 2'd0,
        STEP_LOAD  = 2'd1,
        STEP_MOVE  = 2'd2,
        STEP_BOUND = 2'd3
    } step_kind_t;

    // All-ones value for a counter of the given width (the counter's maximum).
    function automatic gray_word_t all_ones(input int unsigned width);
        gray_word_t v;
        v = {GRAY_MAX_W{1'b0}};
        for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Binary to Gray: G[i] = B[i+1] ^ B[i]; zero-extension keeps the top bit unchanged.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 32'd1);
    endfunction

    // Gray to binary: prefix XOR running down from the MSB.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = {GRAY_MAX_W{1'b0}};
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin2gray_conv.sv
// Parametrised combinational binary-to-Gray converter; supersedes the fixed
// 4-bit converter for new designs.
module bin2gray_conv
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(gray_word_t'(bin)));

endmodule

// File: rtl/gray_counter.sv
// WIDTH-bit up/down counter with registered binary and Gray outputs, parallel
// load, wrap or saturate at the range ends, a terminal-count pulse and a sticky
// overflow flag. The Gray value is converted from the next binary value so both
// outputs update on the same edge.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(all_ones(WIDTH));
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             tc_r;
    logic             ovf_r;

    logic             at_bound_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] wrap_s;
    step_kind_t       step_kind_s;
    logic [WIDTH-1:0] next_bin_s;
    logic [WIDTH-1:0] next_gray_s;
    logic             next_tc_s;
    logic             next_ovf_s;

    // Boundary detection by explicit compare, plus the ordinary step and the wrap target.
    always_comb begin
        at_bound_s = 1'b0;
        step_s     = bin_r;
        wrap_s     = bin_r;
        if (up_dn) begin
            at_bound_s = (bin_r == MAX_VAL);
            step_s     = bin_r + ONE_VAL;
            wrap_s     = ZERO_VAL;
        end else begin
            at_bound_s = (bin_r == ZERO_VAL);
            step_s     = bin_r - ONE_VAL;
            wrap_s     = MAX_VAL;
        end
    end

    // Classify this edge: load beats count enable, which beats hold.
    always_comb begin
        step_kind_s = STEP_HOLD;
        if (load) begin
            step_kind_s = STEP_LOAD;
        end else if (en) begin
            if (at_bound_s) begin
                step_kind_s = STEP_BOUND;
            end else begin
                step_kind_s = STEP_MOVE;
            end
        end else begin
            step_kind_s = STEP_HOLD;
        end
    end

    // Next binary value and flags for the selected action; tc is a one-edge pulse.
    always_comb begin
        next_bin_s = bin_r;
        next_tc_s  = 1'b0;
        next_ovf_s = ovf_r;
        case (step_kind_s)
            STEP_LOAD: begin
                next_bin_s = load_bin;
                next_ovf_s = 1'b0;
            end
            STEP_MOVE: begin
                next_bin_s = step_s;
            end
            STEP_BOUND: begin
                next_tc_s  = 1'b1;
                next_ovf_s = 1'b1;
                if (WRAP) begin
                    next_bin_s = wrap_s;
                end else begin
                    next_bin_s = bin_r;
                end
            end
            STEP_HOLD: begin
                next_bin_s = bin_r;
            end
            default: begin
                next_bin_s = bin_r;
            end
        endcase
    end

    bin2gray_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .bin  (next_bin_s),
        .gray (next_gray_s)
    );

    // Counter state: binary, Gray and flags all register on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r  <= ZERO_VAL;
            gray_r <= ZERO_VAL;
            tc_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            bin_r  <= next_bin_s;
            gray_r <= next_gray_s;
            tc_r   <= next_tc_s;
            ovf_r  <= next_ovf_s;
        end
    end

    assign bin_out  = bin_r;
    assign gray_out = gray_r;
    assign tc       = tc_r;
    assign ovf      = ovf_r;

endmodule
